// File: rtl/comp_mult_pkg.sv
// rtl/comp_mult_pkg.sv - shared types and constants for the complex multiplier traffic generator
package comp_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT_RES,
        ST_DONE
    } state_e;

    localparam logic [31:0] OP_POLY   = 32'h8020_0003;
    localparam logic [15:0] GAP_POLY  = 16'hB400;
    localparam logic [15:0] GAP_SEED  = 16'hACE1;
    // MISR feedback taps: bits 31, 21, 1 and 0
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - right-shift Galois LFSR with synchronous seed load
module lfsr_gen #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = SEED;
        end else if (en) begin
            q_d = (q_q >> 1) ^ (q_q[0] ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/comp_mult_traffic_gen.sv
// rtl/comp_mult_traffic_gen.sv - operand generator and result MISR sink for comp_mult_wrapper
module comp_mult_traffic_gen
    import comp_mult_pkg::*;
#(
    parameter int          DWIDTH  = 8,
    parameter logic [15:0] NUM_OPS = 16'd1000,
    parameter logic [31:0] SEED    = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sw_rst,
    input  logic                    start,
    input  logic [3:0]              gap_max,
    input  logic                    bp_en,
    output logic                    op_val,
    input  logic                    op_rdy,
    output logic [4*DWIDTH-1:0]     op_data,
    input  logic                    res_val,
    output logic                    res_rdy,
    input  logic [4*(DWIDTH+1)-1:0] res_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             sent_cnt,
    output logic [15:0]             rcvd_cnt,
    output logic [31:0]             signature
);

    state_e      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic [15:0] rcvd_cnt_q, rcvd_cnt_d;
    logic [31:0] sig_q, sig_d;
    logic        err_q, err_d;
    logic        res_rdy_q, res_rdy_d;

    logic [31:0] op_q;
    logic [15:0] gap_q;
    logic [3:0]  gap_len;
    logic [63:0] res_ext;
    logic        op_acc, res_acc, start_acc;
    logic        unused_gap;

    assign op_acc    = (state_q == ST_SEND) && op_rdy;
    assign res_acc   = res_val && res_rdy_q;
    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign gap_len   = gap_q[3:0] & gap_max;
    assign res_ext   = {{(64-4*(DWIDTH+1)){1'b0}}, res_data};
    assign unused_gap = ^gap_q[15:6];

    lfsr_gen #(.WIDTH(32), .POLY(OP_POLY), .SEED(SEED)) u_op_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (op_acc),
        .load (sw_rst || start_acc),
        .q    (op_q)
    );

    lfsr_gen #(.WIDTH(16), .POLY(GAP_POLY), .SEED(GAP_SEED)) u_gap_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .load (sw_rst),
        .q    (gap_q)
    );

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        sent_cnt_d = sent_cnt_q;
        rcvd_cnt_d = rcvd_cnt_q;
        sig_d      = sig_q;
        err_d      = err_q;
        res_rdy_d  = !bp_en || (gap_q[5:4] != 2'b00);

        // The sink runs regardless of FSM state so stray results are still captured
        if (res_acc) begin
            rcvd_cnt_d = rcvd_cnt_q + 16'd1;
            sig_d      = {sig_q[30:0], ^(sig_q & MISR_TAPS)} ^ res_ext[31:0] ^ res_ext[63:32];
            if (rcvd_cnt_q == sent_cnt_q) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    sent_cnt_d = '0;
                    rcvd_cnt_d = '0;
                    sig_d      = '0;
                    err_d      = 1'b0;
                end
            end
            ST_SEND: begin
                if (op_acc) begin
                    sent_cnt_d = sent_cnt_q + 16'd1;
                    if (sent_cnt_q + 16'd1 == NUM_OPS) begin
                        state_d = ST_WAIT_RES;
                    end else if (gap_len != 4'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q <= 4'd1) begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_RES: begin
                if (rcvd_cnt_d == NUM_OPS) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sw_rst) begin
            state_d    = ST_IDLE;
            gap_cnt_d  = '0;
            sent_cnt_d = '0;
            rcvd_cnt_d = '0;
            sig_d      = '0;
            err_d      = 1'b0;
            res_rdy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            sent_cnt_q <= '0;
            rcvd_cnt_q <= '0;
            sig_q      <= '0;
            err_q      <= 1'b0;
            res_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            rcvd_cnt_q <= rcvd_cnt_d;
            sig_q      <= sig_d;
            err_q      <= err_d;
            res_rdy_q  <= res_rdy_d;
        end
    end

    assign op_val    = (state_q == ST_SEND);
    assign op_data   = op_q[4*DWIDTH-1:0];
    assign res_rdy   = res_rdy_q;
    assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP) || (state_q == ST_WAIT_RES);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign sent_cnt  = sent_cnt_q;
    assign rcvd_cnt  = rcvd_cnt_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_comp_mult_traffic_gen.sv
// tb/tb_comp_mult_traffic_gen.sv - randomized self-checking bench for comp_mult_traffic_gen
module tb_comp_mult_traffic_gen;

    localparam int          DW   = 8;
    localparam int          N    = 64;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n, sw_rst, start, bp_en, op_rdy, res_val;
    logic [3:0]  gap_max;
    logic        op_val, res_rdy, busy, done, err;
    logic [31:0] op_data, signature;
    logic [35:0] res_data;
    logic [15:0] sent_cnt, rcvd_cnt;

    always #5 clk = ~clk;

    comp_mult_traffic_gen #(.DWIDTH(DW), .NUM_OPS(16'(N)), .SEED(SEED)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_rst   (sw_rst),
        .start    (start),
        .gap_max  (gap_max),
        .bp_en    (bp_en),
        .op_val   (op_val),
        .op_rdy   (op_rdy),
        .op_data  (op_data),
        .res_val  (res_val),
        .res_rdy  (res_rdy),
        .res_data (res_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sent_cnt (sent_cnt),
        .rcvd_cnt (rcvd_cnt),
        .signature(signature)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] op_m, sig_m;
    logic [15:0] gap_m, sent_m, rcvd_m;
    bit          err_m, res_rdy_m, first;
    int          idle, g_exp, opv_cycles;
    logic [31:0] opq[$];
    logic [31:0] acc_log[$];
    int          rdy_pct, res_pct;
    bit          inj_val;
    logic [35:0] inj_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr32(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [15:0] lfsr16(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0);
    endfunction

    function automatic logic [35:0] cmul(input logic [31:0] op);
        logic signed [31:0] x1, y1, x2, y2, xr, yr;
        x1 = 32'($signed(op[31:24]));
        y1 = 32'($signed(op[23:16]));
        x2 = 32'($signed(op[15:8]));
        y2 = 32'($signed(op[7:0]));
        xr = x1 * x2 - y1 * y2;
        yr = x1 * y2 + y1 * x2;
        return {xr[17:0], yr[17:0]};
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [35:0] d);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb} ^ d[31:0] ^ {28'd0, d[35:32]};
    endfunction

    task automatic model_clear();
        op_m = SEED; sig_m = '0; sent_m = '0; rcvd_m = '0; err_m = 0;
        first = 1; idle = 0; g_exp = 0; opv_cycles = 0;
        opq.delete();
        acc_log.delete();
    endtask

    // Called at a negedge: drive inputs, predict the next posedge, advance.
    task automatic run_cycle();
        op_rdy = ($urandom_range(99) < rdy_pct);
        if (inj_val) begin
            res_val = 1'b1; res_data = inj_data;
        end else if (opq.size() > 0 && $urandom_range(99) < res_pct) begin
            res_val = 1'b1; res_data = cmul(opq[0]);
        end else begin
            res_val = 1'b0; res_data = {4'h0, $urandom()};
        end
        #1;
        check("res_rdy", res_rdy, res_rdy_m);
        if (done) check("done_before_all_results", rcvd_m, N);
        if (sw_rst) begin
            model_clear();
        end else begin
            if (res_val && res_rdy) begin
                if (rcvd_m == sent_m) err_m = 1;
                if (opq.size() > 0) void'(opq.pop_front());
                sig_m = misr(sig_m, res_data);
                rcvd_m++;
            end
            if (op_val && op_rdy) begin
                check("op_data", op_data, op_m);
                if (!first) check("gap_len", idle, g_exp);
                first = 0; idle = 0;
                g_exp = int'(gap_m[3:0] & gap_max);
                acc_log.push_back(op_data);
                opq.push_back(op_data);
                op_m = lfsr32(op_m);
                sent_m++;
            end else if (!op_val && sent_m != 0 && sent_m != N) begin
                idle++;
            end
            if (op_val) opv_cycles++;
            if (start) model_clear();
        end
        res_rdy_m = sw_rst ? 1'b0 : (!bp_en || gap_m[5:4] != 2'b00);
        gap_m     = sw_rst ? 16'hACE1 : lfsr16(gap_m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        run_cycle();
        start = 1'b0;
    endtask

    task automatic run_to_done();
        int n = 0;
        while (!done && n < 5000) begin
            run_cycle();
            n++;
        end
        if (!done) check("run_timeout", 0, 1);
    endtask

    task automatic end_checks();
        check("sent_cnt_end", sent_cnt, N);
        check("rcvd_cnt_end", rcvd_cnt, N);
        check("done_end", done, 1);
        check("busy_end", busy, 0);
        check("err_end", err, err_m);
        check("signature_end", signature, sig_m);
    endtask

    task automatic check_first_ops(input string tag);
        logic [31:0] exp_ops[4];
        exp_ops = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
        for (int i = 0; i < 4; i++) begin
            if (acc_log.size() > i) check(tag, acc_log[i], exp_ops[i]);
            else check(tag, 0, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_val"}, op_val, 0);
        check({tag, "_res_rdy"}, res_rdy, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_sent"}, sent_cnt, 0);
        check({tag, "_rcvd"}, rcvd_cnt, 0);
        check({tag, "_sig"}, signature, 0);
        check({tag, "_op_data"}, op_data, SEED);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sw_rst = 1'b0; start = 1'b0; bp_en = 1'b0; gap_max = 4'h0;
        op_rdy = 1'b0; res_val = 1'b0; res_data = '0; inj_val = 0; inj_data = '0;
        rdy_pct = 100; res_pct = 100;
        model_clear();
        gap_m = 16'hACE1; res_rdy_m = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");

        // lone result with no operand outstanding
        inj_val = 1; inj_data = 36'h0_0000_0001;
        run_cycle();
        run_cycle();
        inj_val = 0;
        check("single_sig", signature, 32'h0000_0001);
        check("single_rcvd", rcvd_cnt, 1);
        check("single_err", err, 1);
        check("single_err_model", err, err_m);

        // back-to-back, no backpressure
        gap_max = 4'h0; bp_en = 0; rdy_pct = 100; res_pct = 100;
        do_start();
        run_to_done();
        end_checks();
        check("b2b_op_val_cycles", opv_cycles, N);
        check_first_ops("b2b_op_data");

        // operand stall then random traffic with backpressure
        gap_max = 4'hF;
        do_start();
        rdy_pct = 0;
        for (int i = 0; i < 7; i++) begin
            check("stall_op_val", op_val, 1);
            check("stall_op_data", op_data, SEED);
            check("stall_sent", sent_cnt, 0);
            run_cycle();
        end
        rdy_pct = 70; res_pct = 60; bp_en = 1;
        run_to_done();
        end_checks();

        // maximal gaps against a free-ready sink
        gap_max = 4'hF; bp_en = 0; rdy_pct = 100; res_pct = 100;
        do_start();
        run_to_done();
        end_checks();

        // soft reset while in a gap, with start in the same cycle
        do_start();
        n = 0;
        while (!(busy && !op_val) && n < 300) begin
            run_cycle();
            n++;
        end
        if (!(busy && !op_val)) check("find_gap_timeout", 0, 1);
        sw_rst = 1'b1; start = 1'b1;
        run_cycle();
        sw_rst = 1'b0; start = 1'b0;
        check_reset_outputs("swrst");
        gap_max = 4'h0;
        do_start();
        run_to_done();
        end_checks();
        check_first_ops("replay_op_data");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
